// File: rtl/sobel_core_pipe.sv
// Three-stage Sobel edge core: window -> Gx/Gy -> |Gx|+|Gy| -> output pixel,
// with valid/ready back-pressure, programmable threshold, output modes and border suppression.
module sobel_core_pipe #(
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 10,
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int BORDER_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_0_0_i,
  input  logic [DATA_W-1:0] data_0_1_i,
  input  logic [DATA_W-1:0] data_0_2_i,
  input  logic [DATA_W-1:0] data_1_0_i,
  input  logic [DATA_W-1:0] data_1_1_i,
  input  logic [DATA_W-1:0] data_1_2_i,
  input  logic [DATA_W-1:0] data_2_0_i,
  input  logic [DATA_W-1:0] data_2_1_i,
  input  logic [DATA_W-1:0] data_2_2_i,
  input  logic [CNT_W-1:0]  cnt_col_i,
  input  logic [CNT_W-1:0]  cnt_row_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W+2:0] thresh_i,
  output logic [DATA_W-1:0] pixel_o,
  output logic [CNT_W-1:0]  cnt_col_o,
  output logic [CNT_W-1:0]  cnt_row_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              idle_o
);

  localparam int GW = DATA_W + 3;

  // Weighted 1-2-1 sum, zero-extended so the later subtraction cannot overflow.
  function automatic logic [GW-1:0] wsum(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b,
                                         input logic [DATA_W-1:0] c);
    return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
  endfunction

  function automatic logic [GW-1:0] abs_val(input logic signed [GW-1:0] v);
    return v[GW-1] ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] sat_pix(input logic [GW-1:0] g);
    return (g[GW-1:DATA_W] != '0) ? '1 : g[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] scale_pix(input logic [GW-1:0] g);
    return g[GW-1:3];
  endfunction

  logic vld_p1, vld_p2, vld_p3;
  logic ready_1, ready_2, ready_3;

  assign ready_3     = !vld_p3 || out_ready_i;
  assign ready_2     = !vld_p2 || ready_3;
  assign ready_1     = !vld_p1 || ready_2;
  assign in_ready_o  = ready_1;
  assign out_valid_o = vld_p3;
  assign idle_o      = !(vld_p1 || vld_p2 || vld_p3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      if (ready_1) vld_p1 <= in_valid_i;
      if (ready_2) vld_p2 <= vld_p1;
      if (ready_3) vld_p3 <= vld_p2;
    end
  end

  // S1: gradients, coordinates and border flag
  logic signed [GW-1:0] gx_c, gy_c, gx_p1, gy_p1;
  logic [CNT_W-1:0]     col_p1, row_p1;
  logic                 bdr_c, bdr_p1;

  assign gx_c = $signed(wsum(data_0_2_i, data_1_2_i, data_2_2_i))
              - $signed(wsum(data_0_0_i, data_1_0_i, data_2_0_i));
  assign gy_c = $signed(wsum(data_0_0_i, data_0_1_i, data_0_2_i))
              - $signed(wsum(data_2_0_i, data_2_1_i, data_2_2_i));
  assign bdr_c = (cnt_col_i == '0) || (cnt_col_i == CNT_W'(IMG_W - 1))
              || (cnt_row_i == '0) || (cnt_row_i == CNT_W'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (in_valid_i && ready_1) begin
      gx_p1  <= gx_c;
      gy_p1  <= gy_c;
      col_p1 <= cnt_col_i;
      row_p1 <= cnt_row_i;
      bdr_p1 <= bdr_c;
    end
  end

  // S2: gradient magnitude
  logic [GW-1:0]    g_p2;
  logic [CNT_W-1:0] col_p2, row_p2;
  logic             bdr_p2;

  always_ff @(posedge clk) begin
    if (vld_p1 && ready_2) begin
      g_p2   <= abs_val(gx_p1) + abs_val(gy_p1);
      col_p2 <= col_p1;
      row_p2 <= row_p1;
      bdr_p2 <= bdr_p1;
    end
  end

  // S3: mode selection; mode and threshold are sampled as data enters this stage
  logic              is_edge;
  logic [DATA_W-1:0] pix_c;

  always_comb begin
    is_edge = g_p2 > thresh_i;
    pix_c   = '0;
    case (mode_i)
      2'b00:   pix_c = is_edge ? '1 : '0;
      2'b01:   pix_c = sat_pix(g_p2);
      2'b10:   pix_c = scale_pix(g_p2);
      default: pix_c = is_edge ? '0 : '1;
    endcase
    if (BORDER_ZERO != 0 && bdr_p2) pix_c = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_o   <= '0;
      cnt_col_o <= '0;
      cnt_row_o <= '0;
    end else if (vld_p2 && ready_3) begin
      pixel_o   <= pix_c;
      cnt_col_o <= col_p2;
      cnt_row_o <= row_p2;
    end
  end

endmodule

// File: tb/tb_sobel_core_pipe.sv
// Directed bench for sobel_core_pipe: one instance with border suppression, one without,
// driven in lockstep and checked against hand values and a small scoreboard model.
module tb_sobel_core_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  win [9];
  logic [9:0]  col_in, row_in;
  logic        in_valid, out_ready;
  logic [1:0]  mode;
  logic [10:0] thr;
  logic [71:0] cur_w;

  logic       in_ready, out_valid, idle;
  logic [7:0] pixel;
  logic [9:0] col_out, row_out;
  logic       in_ready_nb, out_valid_nb, idle_nb;
  logic [7:0] pixel_nb;
  logic [9:0] col_out_nb, row_out_nb;

  sobel_core_pipe #(.BORDER_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_0_0_i(win[0]), .data_0_1_i(win[1]), .data_0_2_i(win[2]),
    .data_1_0_i(win[3]), .data_1_1_i(win[4]), .data_1_2_i(win[5]),
    .data_2_0_i(win[6]), .data_2_1_i(win[7]), .data_2_2_i(win[8]),
    .cnt_col_i(col_in), .cnt_row_i(row_in), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .mode_i(mode), .thresh_i(thr), .pixel_o(pixel), .cnt_col_o(col_out), .cnt_row_o(row_out),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .idle_o(idle)
  );

  sobel_core_pipe #(.BORDER_ZERO(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .data_0_0_i(win[0]), .data_0_1_i(win[1]), .data_0_2_i(win[2]),
    .data_1_0_i(win[3]), .data_1_1_i(win[4]), .data_1_2_i(win[5]),
    .data_2_0_i(win[6]), .data_2_1_i(win[7]), .data_2_2_i(win[8]),
    .cnt_col_i(col_in), .cnt_row_i(row_in), .in_valid_i(in_valid), .in_ready_o(in_ready_nb),
    .mode_i(mode), .thresh_i(thr), .pixel_o(pixel_nb), .cnt_col_o(col_out_nb),
    .cnt_row_o(row_out_nb), .out_valid_o(out_valid_nb), .out_ready_i(out_ready), .idle_o(idle_nb)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_win(input logic [71:0] w);
    cur_w = w;
    for (int i = 0; i < 9; i++) win[i] = w[8*i +: 8];
  endtask

  function automatic logic [71:0] rows_same(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c);
    return {c, b, a, c, b, a, c, b, a};
  endfunction

  function automatic logic [71:0] gen_win(input int k);
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[8*i +: 8] = 8'((k * 37 + i * 53 + (i % 3) * 29 + k * k * 11) & 255);
    return w;
  endfunction

  function automatic int model_pix(input logic [71:0] w, input int c, input int r,
                                   input int md, input int th, input bit bz);
    int d [9];
    int gx, gy, g, p;
    for (int i = 0; i < 9; i++) d[i] = int'(w[8*i +: 8]);
    gx = (d[2] + 2 * d[5] + d[8]) - (d[0] + 2 * d[3] + d[6]);
    gy = (d[0] + 2 * d[1] + d[2]) - (d[6] + 2 * d[7] + d[8]);
    g  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    case (md)
      0:       p = (g > th) ? 255 : 0;
      1:       p = (g > 255) ? 255 : g;
      2:       p = g / 8;
      default: p = (g > th) ? 0 : 255;
    endcase
    if (bz && (c == 0 || c == 639 || r == 0 || r == 479)) p = 0;
    return p;
  endfunction

  typedef struct {
    int col;
    int row;
    int pb;
    int pn;
    int acc;
  } exp_t;
  exp_t sb [$];

  bit mon_on = 0;
  bit lat_on = 0;
  int occ = 0;
  int n_blocked = 0;

  // Output monitor: scoreboard, occupancy-derived ready/idle, and hold stability.
  initial begin
    exp_t e;
    bit   in_x, out_x, held_v;
    int   held_pix, held_col, held_row;
    held_v = 0; held_pix = 0; held_col = 0; held_row = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        occ = 0;
        sb.delete();
        held_v = 0;
      end else if (mon_on) begin
        check("idle_vs_occ", int'(idle), int'(occ == 0));
        check("in_ready_vs_occ", int'(in_ready), int'(!(occ == 3 && !out_ready)));
        if (!in_ready) n_blocked++;
        if (held_v) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_pix", int'(pixel), held_pix);
          check("hold_col", int'(col_out), held_col);
          check("hold_row", int'(row_out), held_row);
        end
        out_x = out_valid && out_ready;
        in_x  = in_valid && in_ready;
        if (out_x) begin
          if (sb.size() == 0) begin
            check("spurious_out", 1, 0);
          end else begin
            e = sb.pop_front();
            check("sb_pix", int'(pixel), e.pb);
            check("sb_pix_nb", int'(pixel_nb), e.pn);
            check("sb_col", int'(col_out), e.col);
            check("sb_row", int'(row_out), e.row);
            if (lat_on) check("sb_latency", cyc - e.acc, 3);
          end
        end
        if (in_x) begin
          e.col = int'(col_in);
          e.row = int'(row_in);
          e.pb  = model_pix(cur_w, e.col, e.row, int'(mode), int'(thr), 1'b1);
          e.pn  = model_pix(cur_w, e.col, e.row, int'(mode), int'(thr), 1'b0);
          e.acc = cyc;
          sb.push_back(e);
        end
        occ = occ + int'(in_x) - int'(out_x);
        held_v   = out_valid && !out_ready;
        held_pix = int'(pixel);
        held_col = int'(col_out);
        held_row = int'(row_out);
      end
    end
  end

  // Present the current inputs until accepted; returns just after the accepting edge.
  task automatic wait_accept();
    bit ok = 0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [71:0] w, input int c, input int r,
                         input int md, input int exp_bz, input int exp_nb);
    int n;
    @(posedge clk);
    #1;
    set_win(w);
    col_in = 10'(c); row_in = 10'(r); mode = 2'(md); thr = 11'd255;
    out_ready = 1'b1;
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    n = 0;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      if (out_valid) begin
        n = t;
        break;
      end
    end
    check({tag, "_latency"}, n, 3);
    check({tag, "_pix"}, int'(pixel), exp_bz);
    check({tag, "_pix_nb"}, int'(pixel_nb), exp_nb);
    check({tag, "_col"}, int'(col_out), c);
    check({tag, "_row"}, int'(row_out), r);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_idle"}, int'(idle), 1);
  endtask

  task automatic stream(input int n, input int seed);
    @(posedge clk);
    #1;
    for (int k = 0; k < n; k++) begin
      set_win(gen_win(k + seed));
      col_in = 10'(10 + k);
      row_in = 10'(20 + (k % 7));
      in_valid = 1'b1;
      wait_accept();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && idle) break;
    end
    check({tag, "_drained"}, sb.size(), 0);
  endtask

  localparam logic [71:0] FLAT = {9{8'd100}};
  logic [71:0] edge_w;
  bit stall_done;

  initial begin
    edge_w = rows_same(8'd0, 8'd128, 8'd255);
    set_win(FLAT);
    col_in = '0; row_in = '0; in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00; thr = 11'd255;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_idle", int'(idle), 1);
    check("rst_pixel", int'(pixel), 0);
    check("rst_col", int'(col_out), 0);
    check("rst_row", int'(row_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    mon_on = 1;
    lat_on = 1;

    run_one("edge_m0", edge_w, 5, 5, 0, 255, 255);
    run_one("edge_m1", edge_w, 5, 5, 1, 255, 255);
    run_one("edge_m2", edge_w, 5, 5, 2, 127, 127);
    run_one("edge_m3", edge_w, 5, 5, 3, 0, 0);
    run_one("flat_m0", FLAT, 6, 7, 0, 0, 0);
    run_one("flat_m1", FLAT, 6, 7, 1, 0, 0);
    run_one("flat_m2", FLAT, 6, 7, 2, 0, 0);
    run_one("flat_m3", FLAT, 6, 7, 3, 255, 255);
    run_one("bdr_col0", edge_w, 0, 5, 0, 0, 255);
    run_one("bdr_colmax", edge_w, 639, 5, 0, 0, 255);
    run_one("bdr_row0", edge_w, 5, 0, 0, 0, 255);
    run_one("bdr_rowmax", edge_w, 5, 479, 1, 0, 255);

    mode = 2'b01;
    stream(20, 0);
    drain("b2b");

    lat_on = 0;
    mode = 2'b10;
    n_blocked = 0;
    stall_done = 0;
    fork
      begin
        stream(10, 50);
        stall_done = 1;
      end
      begin
        for (int t = 0; t < 400; t++) begin
          @(posedge clk);
          #1;
          if (t < 5) out_ready = 1'b0;
          else out_ready = 1'($urandom_range(0, 1));
          if (stall_done && sb.size() == 0) break;
        end
        out_ready = 1'b1;
      end
    join
    drain("stall");
    check("stall_backpressure_seen", int'(n_blocked > 0), 1);

    mode = 2'b00;
    stream(3, 80);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_idle", int'(idle), 1);
    check("midrst_pixel", int'(pixel), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("postrst_idle", int'(idle), 1);
    check("postrst_no_valid", int'(out_valid), 0);
    lat_on = 1;
    run_one("postrst", edge_w, 7, 9, 1, 255, 255);
    check("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_core_pipe.md
Name: sobel_core_pipe

Overview:
- Parametrised, fully pipelined successor to the single-stage Sobel edge core.
- Takes a 3x3 pixel window plus its column/row coordinates and computes Gx/Gy and G = |Gx| + |Gy|.
- Emits a binary, saturated or scaled edge pixel with its coordinates through a valid/ready handshake to the accumulator.
- Adds back-pressure, programmable threshold, output modes and image-border suppression.

Parameters:
- DATA_W, 8, pixel width in bits.
- CNT_W, 10, width of the column/row coordinates.
- IMG_W, 640, image width in pixels; used for border detection.
- IMG_H, 480, image height in pixels; used for border detection.
- BORDER_ZERO, 1, 1 = force output to 0 on border pixels; 0 = pass computed value.

Ports:
- clk  in  1  clock; all flops on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_r_c_i (r,c in 0..2, 9 ports)  in  DATA_W  window element (r,c); unsigned.
- cnt_col_i  in  CNT_W  column of the window centre.
- cnt_row_i  in  CNT_W  row of the window centre.
- in_valid_i  in  1  window and coordinates valid.
- in_ready_o  out  1  core accepts the window this cycle.
- mode_i  in  2  00 binary, 01 saturated magnitude, 10 scaled magnitude (G>>3), 11 inverted binary.
- thresh_i  in  DATA_W+3  binary threshold; edge when G > thresh_i.
- pixel_o  out  DATA_W  output pixel.
- cnt_col_o  out  CNT_W  column of pixel_o.
- cnt_row_o  out  CNT_W  row of pixel_o.
- out_valid_o  out  1  pixel_o and coordinates valid.
- out_ready_i  in  1  downstream accepts the output.
- idle_o  out  1  no valid data in any stage.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valids clear to 0, so out_valid_o=0 and idle_o=1.
  - pixel_o=0, cnt_col_o=0, cnt_row_o=0.
  - in_ready_o=1 once reset is released.
  - Reset asserted mid-frame discards all in-flight pixels; no partial output appears afterwards.
- Pipeline: 3 stages (S1, S2, S3). S3 drives the outputs.
  - Stage k has ready_k = !valid_k | ready_(k+1); ready_3 = !valid_3 | out_ready_i.
  - in_ready_o = ready_1.
  - Bubbles collapse, so throughput is 1 pixel/cycle when out_ready_i is held high.
- Transfers:
  - Input transfer when in_valid_i & in_ready_o.
  - Output transfer when out_valid_o & out_ready_i.
  - Latency: an accepted window appears on out_valid_o exactly 3 cycles later if there is no stall.
- S1: register Gx and Gy, each signed DATA_W+3 bits (range +/-4*(2^DATA_W-1)).
  - Gx = (d02 + 2*d12 + d22) - (d00 + 2*d10 + d20).
  - Gy = (d00 + 2*d01 + d02) - (d20 + 2*d21 + d22).
  - All arithmetic is zero-extended before subtraction; there is no overflow.
  - S1 also registers the coordinates and a border flag.
  - Border flag = col==0 | col==IMG_W-1 | row==0 | row==IMG_H-1.
- S2: register G = |Gx| + |Gy|, unsigned DATA_W+3 bits; maximum 8*(2^DATA_W-1), which fits.
- S3: register pixel_o according to mode:
  - 00: all-ones if G > thresh_i, else 0.
  - 01: min(G, 2^DATA_W-1).
  - 10: G>>3 (always fits).
  - 11: 0 if G > thresh_i, else all-ones.
  - If BORDER_ZERO=1 and the border flag is set, pixel_o=0 in every mode.
- Stall: while valid_k & !ready_(k+1), stage k holds its data and coordinates unchanged; no data is dropped or duplicated.
- Output stability: while out_valid_o=1 and out_ready_i=0, pixel_o and coordinates remain stable.
- Configuration timing:
  - mode_i and thresh_i are sampled in S3 when data moves into S3.
  - The integrator changes them only while idle_o=1; a change while busy is allowed but affects in-flight pixels.
- idle_o = !(valid_1 | valid_2 | valid_3), registered-derived.
- Simultaneous input accept and output drain in the same cycle with the pipeline full: both occur and occupancy is unchanged.

Test Plan:
- Reset, then a single window with left column 0 and right column 255 (Gx=1020, Gy=0), coord (5,5), mode 00, thresh 255, out_ready_i=1 -> out_valid_o high 3 cycles after accept; pixel_o=255, col=5, row=5, idle_o returns to 1.
- Same window in each mode (thresh 255) -> mode 01 pixel_o=255, mode 10 pixel_o=127, mode 11 pixel_o=0; a flat window of all 100s gives 0/0/0/255.
- Stream 20 windows back-to-back with out_ready_i=1 -> 20 outputs on consecutive cycles, in order, with coordinates matching the inputs.
- Stream 10 windows while toggling out_ready_i pseudo-randomly -> no loss or duplication; outputs hold stable while stalled; in_ready_o drops only once all 3 stages are full.
- Edge window at col=0, col=IMG_W-1, row=0 and row=IMG_H-1 with BORDER_ZERO=1 -> pixel_o=0; the same windows with BORDER_ZERO=0 -> computed values.
- Assert rst_n low for 1 cycle with 3 pixels in flight -> out_valid_o=0 immediately; no stale outputs after release; the next accepted pixel has 3-cycle latency.
